// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage in front of instruction_memory. Owns the PC, drives it onto the
//   memory's combinational read port, and registers the returned instruction
//   with its PC into an IF/ID slot handed to decode with valid/ready.
//   Redirects flush the slot. An out-of-range or misaligned fetch address
//   latches a sticky fault and parks the unit in HALT until reset.
//
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   pc                 fetch address to instruction_memory
//   instruction_code   combinational read data for pc
//   id_ready           decode accepts the slot this cycle
//   redirect_valid     branch/jump taken, flush request
//   redirect_target    new fetch PC
//   if_valid, if_instr, if_pc   IF/ID output slot
//   fetch_fault        sticky fault flag (HALT)
//   fault_pc           offending PC
//
// Optional macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_fetched, perf_stall, perf_flush.
//
// state | meaning
// IDLE  | one settle edge after reset, no fetch
// RUN   | normal fetch: redirect > stall > advance
// HALT  | fault taken, frozen until reset

module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 109,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction_code,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    // Largest word-aligned address whose full 4-byte word fits in memory.
    localparam logic [31:0] LAST_PC = 32'(((IMEM_BYTES - 4) / 4) * 4);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt, ifpc_nxt, fpc_nxt;
    logic        valid_nxt, fault_nxt;
    logic        do_fetch, do_stall, do_flush;

    function automatic logic pc_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_PC);
    endfunction

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = if_valid;
        instr_nxt = if_instr;
        ifpc_nxt  = if_pc;
        fault_nxt = fetch_fault;
        fpc_nxt   = fault_pc;
        do_fetch  = 1'b0;
        do_flush  = 1'b0;
        do_stall  = (state == RUN) && if_valid && !id_ready;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (redirect_valid) begin
                    // Any slot accepted this cycle is simply dropped from
                    // our side; the flush empties the slot either way.
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    if (!pc_legal(redirect_target)) begin
                        state_nxt = HALT;
                        fault_nxt = 1'b1;
                        fpc_nxt   = redirect_target;
                    end else begin
                        pc_nxt   = redirect_target;
                        do_flush = 1'b1;
                    end
                end else if (if_valid && !id_ready) begin
                    // stall: everything holds
                end else if (pc_legal(pc)) begin
                    // instruction_code is only looked at here, so X on the
                    // read port outside fetch edges never reaches state.
                    instr_nxt = instruction_code;
                    ifpc_nxt  = pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    do_fetch  = 1'b1;
                end else begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                    fpc_nxt   = pc;
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
                instr_nxt = NOP_INSTR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'd0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_valid    <= valid_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= ifpc_nxt;
            fetch_fault <= fault_nxt;
            fault_pc    <= fpc_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Events only occur in RUN, so the counters are naturally frozen in HALT.
    // A redirect that faults is not an accepted flush and is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
            perf_flush   <= 32'd0;
        end else begin
            if (do_fetch && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (do_stall && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
            if (do_flush && perf_flush != 32'hFFFF_FFFF)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = do_fetch ^ do_stall ^ do_flush;
`endif

endmodule
